counter_forward_timer: RTL and testbench

Programmable up-counting timer, the forward-direction counterpart to the team's backward (down) counter. It counts up from a loaded start value to a runtime limit and wraps through zero when needed. On reaching the limit it either stops (one-shot) or reloads (auto-reload). Each terminal count is reported as an event on a valid/ready handshake, with a sticky overrun flag for unacknowledged events. Used as the periodic tick/timeout source beside the counter utilities.

---
 rtl/counter_forward_timer.sv | 111 +++++++++++
 tb/tb_counter_forward_timer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_forward_timer.sv
// Programmable up-counting timer: counts from a loaded start value to a live limit,
// then stops or reloads, and reports each terminal count on a valid/ready event.
module counter_forward_timer #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  load_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    input  logic [WORD_WIDTH-1:0] limit_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  auto_reload_i,
    input  logic                  event_ready_i,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  will_overflow_o,
    output logic                  event_valid_o,
    output logic                  overrun_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [WORD_WIDTH-1:0] count;
    logic [WORD_WIDTH-1:0] reload;
    logic                  event_valid;
    logic                  overrun;
    logic                  terminal;
    logic                  accept;

    // A terminal fires only while running and not being loaded or paused on this edge.
    always_comb begin
        terminal = 1'b0;
        if (!load_i && state == RUN && !stop_i && count == limit_i) begin
            terminal = 1'b1;
        end
    end

    assign accept = event_valid && event_ready_i;

    // NOTE: sequential state uses non-blocking assignments so every register sees
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state       <= IDLE;
            count       <= '0;
            reload      <= '0;
            event_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (load_i) begin
                state   <= IDLE;
                count   <= data_i;
                reload  <= data_i;
                overrun <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (!stop_i && start_i) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (stop_i) begin
                            state <= IDLE;
                        end else if (terminal) begin
                            if (auto_reload_i) begin
                                count <= reload;
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    DONE: begin
                        if (!stop_i && start_i) begin
                            state <= RUN;
                            count <= reload;
                        end
                    end
                    default: state <= IDLE;
                endcase
                // An unaccepted pending event absorbs the new terminal and flags overrun.
                if (terminal && event_valid && !event_ready_i) begin
                    overrun <= 1'b1;
                end
            end

            if (terminal) begin
                event_valid <= 1'b1;
            end else if (accept) begin
                event_valid <= 1'b0;
            end
        end
    end

    assign data_o          = count;
    assign will_overflow_o = (state == RUN) && (&count);
    assign event_valid_o   = event_valid;
    assign overrun_o       = overrun;
    assign busy_o          = (state == RUN);
    assign done_o          = (state == DONE);

endmodule

// File: tb/tb_counter_forward_timer.sv
// Directed self-checking bench for counter_forward_timer with hand-computed expectations.
module tb_counter_forward_timer;

    logic       clk_i = 1'b0;
    logic       arst_ni;
    logic       load_i;
    logic [7:0] data_i;
    logic [7:0] limit_i;
    logic       start_i;
    logic       stop_i;
    logic       auto_reload_i;
    logic       event_ready_i;
    logic [7:0] data_o;
    logic       will_overflow_o;
    logic       event_valid_o;
    logic       overrun_o;
    logic       busy_o;
    logic       done_o;

    int total = 0;
    int bad   = 0;

    counter_forward_timer #(.WORD_WIDTH(8)) dut (
        .clk_i           (clk_i),
        .arst_ni         (arst_ni),
        .load_i          (load_i),
        .data_i          (data_i),
        .limit_i         (limit_i),
        .start_i         (start_i),
        .stop_i          (stop_i),
        .auto_reload_i   (auto_reload_i),
        .event_ready_i   (event_ready_i),
        .data_o          (data_o),
        .will_overflow_o (will_overflow_o),
        .event_valid_o   (event_valid_o),
        .overrun_o       (overrun_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_load(input logic [7:0] d, input logic [7:0] lim,
                           input logic ar, input logic rdy);
        load_i        = 1'b1;
        data_i        = d;
        limit_i       = lim;
        auto_reload_i = ar;
        event_ready_i = rdy;
        tick();
        load_i = 1'b0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    logic [7:0] ar_data  [6] = '{8'd3, 8'd4, 8'd2, 8'd3, 8'd4, 8'd2};
    logic       ar_valid [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        arst_ni       = 1'b0;
        load_i        = 1'b0;
        data_i        = '0;
        limit_i       = '0;
        start_i       = 1'b0;
        stop_i        = 1'b0;
        auto_reload_i = 1'b0;
        event_ready_i = 1'b0;
        #12;
        check("rst_data",  data_o, 0);
        check("rst_valid", event_valid_o, 0);
        check("rst_busy",  busy_o, 0);
        check("rst_done",  done_o, 0);
        arst_ni = 1'b1;
        tick();

        // One-shot: load 5, limit 8
        do_load(8'd5, 8'd8, 1'b0, 1'b0);
        check("os_load", data_o, 5);
        do_start();
        check("os_start_data", data_o, 5);
        check("os_start_busy", busy_o, 1);
        tick(); check("os_e1", data_o, 6);
        tick(); check("os_e2", data_o, 7);
        tick(); check("os_e3", data_o, 8);
        check("os_e3_valid", event_valid_o, 0);
        tick();
        check("os_e4_valid", event_valid_o, 1);
        check("os_e4_done",  done_o, 1);
        check("os_e4_data",  data_o, 8);
        event_ready_i = 1'b1;
        tick();
        check("os_ack_valid", event_valid_o, 0);
        check("os_hold_data", data_o, 8);
        event_ready_i = 1'b0;
        do_start();
        check("os_restart_data", data_o, 5);
        check("os_restart_busy", busy_o, 1);

        // Auto-reload: load 2, limit 4, ready tied high
        do_load(8'd2, 8'd4, 1'b1, 1'b1);
        do_start();
        check("ar_start", data_o, 2);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("ar_data%0d", i),  data_o, ar_data[i]);
            check($sformatf("ar_valid%0d", i), event_valid_o, ar_valid[i]);
        end
        check("ar_overrun", overrun_o, 0);

        // Overrun and same-edge handshake
        do_load(8'd2, 8'd4, 1'b1, 1'b0);
        tick();                                  // let any leftover valid drain? ready=0 holds it
        event_ready_i = 1'b1;
        tick();
        event_ready_i = 1'b0;
        check("ov_clear_valid", event_valid_o, 0);
        do_start();
        tick(); tick();
        check("ov_at_limit", data_o, 4);
        tick();
        check("ov_t1_valid", event_valid_o, 1);
        check("ov_t1_overrun", overrun_o, 0);
        tick(); tick();
        event_ready_i = 1'b1;
        tick();
        event_ready_i = 1'b0;
        check("ov_same_edge_valid", event_valid_o, 1);
        check("ov_same_edge_overrun", overrun_o, 0);
        tick(); tick(); tick();
        check("ov_t3_overrun", overrun_o, 1);
        check("ov_t3_valid", event_valid_o, 1);
        check("ov_t3_data", data_o, 2);
        do_load(8'd9, 8'd4, 1'b1, 1'b0);
        check("ov_load_overrun", overrun_o, 0);
        check("ov_load_valid", event_valid_o, 1);
        check("ov_load_data", data_o, 9);
        check("ov_load_busy", busy_o, 0);
        event_ready_i = 1'b1;
        tick();
        check("ov_ack", event_valid_o, 0);

        // Wrap-around: load 254, limit 1
        do_load(8'd254, 8'd1, 1'b0, 1'b1);
        do_start();
        check("wr_254", data_o, 254);
        check("wr_254_wo", will_overflow_o, 0);
        tick(); check("wr_255", data_o, 255);
        check("wr_255_wo", will_overflow_o, 1);
        tick(); check("wr_0", data_o, 0);
        check("wr_0_wo", will_overflow_o, 0);
        tick(); check("wr_1", data_o, 1);
        check("wr_1_valid", event_valid_o, 0);
        tick();
        check("wr_event", event_valid_o, 1);
        check("wr_done", done_o, 1);
        tick();
        check("wr_ack", event_valid_o, 0);

        // Pause and priority
        do_load(8'd0, 8'd10, 1'b0, 1'b1);
        do_start();
        tick(); tick(); tick();
        check("pp_at3", data_o, 3);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("pp_stop_data", data_o, 3);
        check("pp_stop_busy", busy_o, 0);
        tick();
        check("pp_hold", data_o, 3);
        start_i = 1'b1; stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("pp_both_busy", busy_o, 0);
        tick();
        start_i = 1'b0;
        check("pp_resume_busy", busy_o, 1);
        check("pp_resume_data", data_o, 3);
        tick();
        check("pp_resume_inc", data_o, 4);
        start_i = 1'b1; load_i = 1'b1; data_i = 8'd77;
        tick();
        start_i = 1'b0; load_i = 1'b0;
        check("pp_load_busy", busy_o, 0);
        check("pp_load_data", data_o, 77);

        // Reset mid-run with an event pending
        do_load(8'd2, 8'd4, 1'b1, 1'b0);
        do_start();
        tick(); tick(); tick();
        check("rm_pending", event_valid_o, 1);
        #2 arst_ni = 1'b0;
        #1;
        check("rm_data",    data_o, 0);
        check("rm_valid",   event_valid_o, 0);
        check("rm_overrun", overrun_o, 0);
        check("rm_busy",    busy_o, 0);
        #3 arst_ni = 1'b1;
        tick(); tick();
        check("rm_idle_data", data_o, 0);
        check("rm_idle_busy", busy_o, 0);
        do_start();
        check("rm_start_busy", busy_o, 1);
        tick();
        check("rm_count", data_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
